packet_fragmenter_v2: RTL and testbench

PACKET_FRAGMENTER_V2 -- requirements
Module: packet_fragmenter_v2

---
 rtl/packet_frag_pkg.sv | 21 ++
 rtl/axis_skid_reg.sv | 55 +++++
 rtl/packet_fragmenter_v2.sv | 161 ++++++++++++++++
 tb/tb_packet_fragmenter_v2.sv | 358 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/packet_frag_pkg.sv
// Shared FSM encodings and gap-mode constants for the packet fragmenter.
package packet_frag_pkg;

  typedef enum logic [1:0] {
    ST_WAIT_TRIGGER = 2'd0,
    ST_SEND         = 2'd1,
    ST_GAP          = 2'd2,
    ST_DRAIN        = 2'd3
  } frag_state_e;

  localparam logic [1:0] MODE_IFG       = 2'd0;
  localparam logic [1:0] MODE_SIDE_INFO = 2'd1;
  localparam logic [1:0] MODE_REPEAT    = 2'd2;
  localparam logic [1:0] MODE_RESERVED  = 2'd3;

  // Every mode except side-info times its gap with the IFG counter.
  function automatic logic gap_uses_ifg(input logic [1:0] mode);
    return mode != MODE_SIDE_INFO;
  endfunction

endpackage

// File: rtl/axis_skid_reg.sv
// Two-entry skid buffer: a registered output stage plus one overflow slot so the
// upstream ready is a register and full throughput survives downstream stalls.
module axis_skid_reg #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         srst,
  input  logic [W-1:0] data_i,
  input  logic         valid_i,
  output logic         ready_o,
  output logic [W-1:0] data_o,
  output logic         valid_o,
  input  logic         ready_i,
  output logic         empty_o,
  output logic         single_o
);

  logic [W-1:0] out_data_q;
  logic [W-1:0] skid_data_q;
  logic         out_valid_q;
  logic         skid_valid_q;
  logic         in_fire;
  logic         out_free;

  assign ready_o  = !skid_valid_q;
  assign in_fire  = valid_i && ready_o;
  assign out_free = !out_valid_q || ready_i;
  assign data_o   = out_data_q;
  assign valid_o  = out_valid_q;
  assign empty_o  = !out_valid_q && !skid_valid_q;
  assign single_o = out_valid_q && !skid_valid_q;

  always_ff @(posedge clk) begin
    if (srst) begin
      out_data_q   <= '0;
      skid_data_q  <= '0;
      out_valid_q  <= 1'b0;
      skid_valid_q <= 1'b0;
    end else if (out_free) begin
      // The parked beat is older than anything upstream, so it goes out first.
      if (skid_valid_q) begin
        out_data_q   <= skid_data_q;
        out_valid_q  <= 1'b1;
        skid_valid_q <= 1'b0;
      end else begin
        out_valid_q <= in_fire;
        if (in_fire) out_data_q <= data_i;
      end
    end else if (in_fire) begin
      skid_data_q  <= data_i;
      skid_valid_q <= 1'b1;
    end
  end

endmodule

// File: rtl/packet_fragmenter_v2.sv
// Splits an untagged AXI-Stream transfer into tlast-delimited fragments separated
// by an IFG count, a side-info handshake, or continuous repetition.
module packet_fragmenter_v2
  import packet_frag_pkg::*;
#(
  parameter int DATA_W = 64,
  parameter int USER_W = 1,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              arst,
  input  logic [DATA_W-1:0] s_axis_tdata,
  input  logic              s_axis_tvalid,
  output logic              s_axis_tready,
  input  logic [USER_W-1:0] s_axis_tuser,
  output logic [DATA_W-1:0] m_axis_tdata,
  output logic              m_axis_tvalid,
  input  logic              m_axis_tready,
  output logic              m_axis_tlast,
  output logic [USER_W-1:0] m_axis_tuser,
  input  logic              trigger,
  input  logic [1:0]        mode,
  input  logic [CNT_W-1:0]  transfer_size,
  input  logic [CNT_W-1:0]  mss,
  input  logic [CNT_W-1:0]  ifg,
  input  logic              side_info_completed,
  output logic              transfer_init,
  output logic              transfer_completed,
  output logic              slot_processed,
  output logic [CNT_W-1:0]  frag_count
);

  localparam int SKID_W = USER_W + 1 + DATA_W;
  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  frag_state_e      state_q;
  logic             trig_q;
  logic [1:0]       mode_q;
  logic [CNT_W-1:0] size_q;
  logic [CNT_W-1:0] mss_q;
  logic [CNT_W-1:0] ifg_q;
  logic [CNT_W-1:0] total_q;
  logic [CNT_W-1:0] beat_q;
  logic [CNT_W-1:0] gap_q;
  logic [CNT_W-1:0] frag_cnt_q;
  logic             done_q;

  logic              trig_edge;
  logic              in_fire;
  logic              out_fire;
  logic              last_frag;
  logic              last_xfer;
  logic              skid_ready;
  logic              skid_empty;
  logic              skid_single;
  logic [SKID_W-1:0] skid_out;

  assign trig_edge     = trigger & ~trig_q;
  assign s_axis_tready = (state_q == ST_SEND) && skid_ready;
  assign in_fire       = s_axis_tvalid && s_axis_tready;
  assign out_fire      = m_axis_tvalid && m_axis_tready;
  assign last_frag     = (mss_q != '0) && (beat_q == mss_q - ONE);
  assign last_xfer     = (total_q == size_q - ONE);

  axis_skid_reg #(
    .W (SKID_W)
  ) u_skid (
    .clk      (clk),
    .srst     (arst),
    .data_i   ({s_axis_tuser, last_frag | last_xfer, s_axis_tdata}),
    .valid_i  (in_fire),
    .ready_o  (skid_ready),
    .data_o   (skid_out),
    .valid_o  (m_axis_tvalid),
    .ready_i  (m_axis_tready),
    .empty_o  (skid_empty),
    .single_o (skid_single)
  );

  assign {m_axis_tuser, m_axis_tlast, m_axis_tdata} = skid_out;
  assign transfer_init      = (state_q != ST_WAIT_TRIGGER);
  assign transfer_completed = done_q;
  assign slot_processed     = done_q;
  assign frag_count         = frag_cnt_q;

  always_ff @(posedge clk) begin
    if (arst) begin
      state_q    <= ST_WAIT_TRIGGER;
      // Sampling the live trigger keeps a level held through reset from looking like an edge.
      trig_q     <= trigger;
      mode_q     <= MODE_IFG;
      size_q     <= '0;
      mss_q      <= '0;
      ifg_q      <= '0;
      total_q    <= '0;
      beat_q     <= '0;
      gap_q      <= '0;
      frag_cnt_q <= '0;
      done_q     <= 1'b0;
    end else begin
      trig_q <= trigger;
      done_q <= 1'b0;
      if (out_fire && m_axis_tlast) frag_cnt_q <= frag_cnt_q + ONE;
      // In DRAIN no new beats enter, so the last buffered tlast beat ends the transfer.
      if (state_q == ST_DRAIN && out_fire && m_axis_tlast && skid_single) done_q <= 1'b1;

      case (state_q)
        ST_WAIT_TRIGGER: begin
          if (trig_edge) begin
            mode_q     <= mode;
            size_q     <= transfer_size;
            mss_q      <= mss;
            ifg_q      <= ifg;
            total_q    <= '0;
            beat_q     <= '0;
            gap_q      <= '0;
            frag_cnt_q <= '0;
            if (transfer_size == '0) done_q  <= 1'b1;
            else                     state_q <= ST_SEND;
          end
        end
        ST_SEND: begin
          if (in_fire) begin
            total_q <= total_q + ONE;
            if (last_xfer) begin
              state_q <= ST_DRAIN;
            end else if (last_frag) begin
              beat_q <= '0;
              gap_q  <= '0;
              if (!(gap_uses_ifg(mode_q) && ifg_q == '0)) state_q <= ST_GAP;
            end else begin
              beat_q <= beat_q + ONE;
            end
          end
        end
        ST_GAP: begin
          if (gap_uses_ifg(mode_q)) begin
            if (gap_q == ifg_q - ONE) state_q <= ST_SEND;
            else                      gap_q   <= gap_q + ONE;
          end else if (side_info_completed) begin
            state_q <= ST_SEND;
          end
        end
        ST_DRAIN: begin
          if (skid_empty) begin
            if (mode_q == MODE_REPEAT && trigger) begin
              state_q    <= ST_SEND;
              total_q    <= '0;
              beat_q     <= '0;
              frag_cnt_q <= '0;
            end else begin
              state_q <= ST_WAIT_TRIGGER;
            end
          end
        end
        default: state_q <= ST_WAIT_TRIGGER;
      endcase
    end
  end

endmodule

// File: tb/tb_packet_fragmenter_v2.sv
// Directed scoreboard bench: expected beats are queued at stimulus time and a
// negedge monitor pops and compares every beat the fragmenter delivers.
module tb_packet_fragmenter_v2;

  localparam int DATA_W = 64;
  localparam int USER_W = 1;
  localparam int CNT_W  = 32;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic              last;
    logic [USER_W-1:0] user;
  } beat_t;

  logic              clk = 1'b0;
  logic              arst;
  logic [DATA_W-1:0] s_axis_tdata;
  logic              s_axis_tvalid;
  logic              s_axis_tready;
  logic [USER_W-1:0] s_axis_tuser;
  logic [DATA_W-1:0] m_axis_tdata;
  logic              m_axis_tvalid;
  logic              m_axis_tready;
  logic              m_axis_tlast;
  logic [USER_W-1:0] m_axis_tuser;
  logic              trigger;
  logic [1:0]        mode;
  logic [CNT_W-1:0]  transfer_size;
  logic [CNT_W-1:0]  mss;
  logic [CNT_W-1:0]  ifg;
  logic              side_info_completed;
  logic              transfer_init;
  logic              transfer_completed;
  logic              slot_processed;
  logic [CNT_W-1:0]  frag_count;

  beat_t exp_q[$];
  int    fire_cyc[$];
  int    vectors = 0;
  int    miscompares = 0;
  int    done_cnt = 0;
  int    last_done_cyc = -1;
  int    cyc_cnt = 0;
  int    src_cnt = 0;
  logic  mon_en = 1'b0;
  logic  rnd_ready = 1'b0;
  logic  tready_fix = 1'b1;

  always #5 clk = ~clk;
  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  packet_fragmenter_v2 #(
    .DATA_W (DATA_W),
    .USER_W (USER_W),
    .CNT_W  (CNT_W)
  ) dut (
    .clk                 (clk),
    .arst                (arst),
    .s_axis_tdata        (s_axis_tdata),
    .s_axis_tvalid       (s_axis_tvalid),
    .s_axis_tready       (s_axis_tready),
    .s_axis_tuser        (s_axis_tuser),
    .m_axis_tdata        (m_axis_tdata),
    .m_axis_tvalid       (m_axis_tvalid),
    .m_axis_tready       (m_axis_tready),
    .m_axis_tlast        (m_axis_tlast),
    .m_axis_tuser        (m_axis_tuser),
    .trigger             (trigger),
    .mode                (mode),
    .transfer_size       (transfer_size),
    .mss                 (mss),
    .ifg                 (ifg),
    .side_info_completed (side_info_completed),
    .transfer_init       (transfer_init),
    .transfer_completed  (transfer_completed),
    .slot_processed      (slot_processed),
    .frag_count          (frag_count)
  );

  function automatic logic [DATA_W-1:0] data_of(input int n);
    return {32'hA5C3_0F1E, 32'(n)};
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  task automatic push_xfer(input int base, input int n, input logic [31:0] last_mask);
    beat_t b;
    for (int i = 0; i < n; i++) begin
      b.data = data_of(base + i);
      b.last = last_mask[i];
      b.user = USER_W'((base + i) & 1);
      exp_q.push_back(b);
    end
  endtask

  task automatic start(input logic [1:0] m, input int size, input int ms, input int ig);
    mode          = m;
    transfer_size = CNT_W'(size);
    mss           = CNT_W'(ms);
    ifg           = CNT_W'(ig);
    $display("xfer: mode=%0d size=%0d mss=%0d ifg=%0d first_beat=%0d", m, size, ms, ig, src_cnt);
    @(posedge clk); #1;
    trigger = 1'b1;
    @(posedge clk); #1;
    trigger = 1'b0;
  endtask

  task automatic wait_done(input int target, input int budget);
    int k = 0;
    while (done_cnt < target && k < budget) begin
      @(posedge clk); #1;
      k++;
    end
    check("done_count", 128'(done_cnt), 128'(target));
  endtask

  task automatic wait_fires(input int n, input int budget);
    int k = 0;
    while (fire_cyc.size() < n && k < budget) begin
      @(posedge clk); #1;
      k++;
    end
    check("fire_count", 128'(fire_cyc.size()), 128'(n));
  endtask

  task automatic wait_drain(input int budget);
    int k = 0;
    while (exp_q.size() != 0 && k < budget) begin
      @(posedge clk); #1;
      k++;
    end
    check("scoreboard_drained", 128'(exp_q.size()), 128'(0));
  endtask

  // Source: always offers the next numbered beat, advancing only on acceptance.
  initial begin : source
    logic fire;
    s_axis_tvalid = 1'b1;
    s_axis_tdata  = data_of(0);
    s_axis_tuser  = '0;
    forever begin
      @(negedge clk);
      fire = s_axis_tvalid && s_axis_tready;
      @(posedge clk); #1;
      if (fire === 1'b1) begin
        src_cnt++;
        s_axis_tdata = data_of(src_cnt);
        s_axis_tuser = USER_W'(src_cnt & 1);
      end
    end
  end

  initial begin : sink
    m_axis_tready = 1'b1;
    forever begin
      @(posedge clk); #1;
      m_axis_tready = rnd_ready ? 1'($urandom_range(0, 1)) : tready_fix;
    end
  end

  initial begin : monitor
    beat_t e;
    beat_t prev_beat;
    logic  prev_stall;
    prev_stall = 1'b0;
    prev_beat  = '0;
    forever begin
      @(negedge clk);
      if (arst !== 1'b0) begin
        prev_stall = 1'b0;
      end else if (mon_en) begin
        if (prev_stall) begin
          check("stall_hold_valid", 128'(m_axis_tvalid), 128'(1));
          check("stall_hold_beat", 128'({m_axis_tdata, m_axis_tlast, m_axis_tuser}), 128'(prev_beat));
        end
        if (m_axis_tvalid === 1'b1 && m_axis_tready === 1'b1) begin
          fire_cyc.push_back(cyc_cnt);
          if (exp_q.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL unexpected_beat: got data %0h last %0b, required no beat", m_axis_tdata, m_axis_tlast);
          end else begin
            e = exp_q.pop_front();
            check("out_beat", 128'({m_axis_tdata, m_axis_tlast, m_axis_tuser}), 128'(e));
          end
        end
        if (transfer_completed === 1'b1) begin
          done_cnt++;
          last_done_cyc = cyc_cnt;
        end
        if (transfer_completed === 1'b1 || slot_processed === 1'b1)
          check("slot_alias", 128'(slot_processed), 128'(transfer_completed));
        prev_stall = (m_axis_tvalid === 1'b1) && (m_axis_tready !== 1'b1);
        prev_beat  = {m_axis_tdata, m_axis_tlast, m_axis_tuser};
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "bench timeout");
  end

  initial begin : main
    int k;
    arst = 1'b1;
    trigger = 1'b0;
    mode = 2'd0;
    transfer_size = '0;
    mss = '0;
    ifg = '0;
    side_info_completed = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_m_tvalid", 128'(m_axis_tvalid), 128'(0));
    check("rst_s_tready", 128'(s_axis_tready), 128'(0));
    check("rst_init", 128'(transfer_init), 128'(0));
    check("rst_frag_count", 128'(frag_count), 128'(0));
    check("rst_done", 128'(transfer_completed), 128'(0));
    arst = 1'b0;
    mon_en = 1'b1;

    // Mode 0: 10 beats in fragments of 4/4/2, 3-cycle gaps; parameters changed mid-flight.
    fire_cyc.delete();
    push_xfer(src_cnt, 10, 32'b10_1000_1000);
    start(2'd0, 10, 4, 3);
    transfer_size = 99; mss = 2; ifg = 0; mode = 2'd1;
    wait_done(1, 200);
    wait_drain(50);
    repeat (2) @(posedge clk);
    #1;
    check("m0_frag_count", 128'(frag_count), 128'(3));
    check("m0_init_idle", 128'(transfer_init), 128'(0));
    if (fire_cyc.size() >= 10) begin
      check("m0_burst_len", 128'(fire_cyc[3] - fire_cyc[0]), 128'(3));
      check("m0_gap1", 128'(fire_cyc[4] - fire_cyc[3]), 128'(4));
      check("m0_gap2", 128'(fire_cyc[8] - fire_cyc[7]), 128'(4));
    end else begin
      check("m0_fire_total", 128'(fire_cyc.size()), 128'(10));
    end

    // Same transfer under random back-pressure.
    rnd_ready = 1'b1;
    push_xfer(src_cnt, 10, 32'b10_1000_1000);
    start(2'd0, 10, 4, 3);
    wait_done(2, 600);
    wait_drain(50);
    rnd_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("m0r_frag_count", 128'(frag_count), 128'(3));

    // Mode 1: the gap is released only by side_info_completed.
    fire_cyc.delete();
    push_xfer(src_cnt, 8, 32'b1000_1000);
    start(2'd1, 8, 4, 0);
    wait_fires(4, 100);
    repeat (20) @(posedge clk);
    #1;
    check("m1_gap_holds", 128'(fire_cyc.size()), 128'(4));
    k = cyc_cnt;
    side_info_completed = 1'b1;
    @(posedge clk); #1;
    side_info_completed = 1'b0;
    wait_done(3, 100);
    wait_drain(50);
    if (fire_cyc.size() >= 5) check("m1_release_cycle", 128'(fire_cyc[4]), 128'(k + 2));
    else                      check("m1_fire_total", 128'(fire_cyc.size()), 128'(8));

    // Mode 2: trigger held repeats 3-beat transfers; dropped during the third.
    push_xfer(src_cnt, 9, 32'b1_0010_0100);
    mode = 2'd2; transfer_size = 3; mss = 0; ifg = 0;
    $display("xfer: mode=2 size=3 mss=0 trigger held, first_beat=%0d", src_cnt);
    @(posedge clk); #1;
    trigger = 1'b1;
    k = 0;
    while (done_cnt < 5 && k < 200) begin
      @(posedge clk); #1;
      k++;
    end
    trigger = 1'b0;
    wait_done(6, 100);
    wait_drain(50);
    repeat (10) @(posedge clk);
    #1;
    check("m2_frag_count", 128'(frag_count), 128'(1));
    check("m2_back_to_wait", 128'(transfer_init), 128'(0));
    check("m2_no_extra_done", 128'(done_cnt), 128'(6));

    // Zero-size transfer: a lone done pulse one cycle after the edge, no beats.
    fire_cyc.delete();
    mode = 2'd0; transfer_size = 0; mss = 0; ifg = 0;
    $display("xfer: mode=0 size=0 trigger held, first_beat=%0d", src_cnt);
    @(posedge clk); #1;
    trigger = 1'b1;
    k = cyc_cnt;
    repeat (20) @(posedge clk);
    #1;
    trigger = 1'b0;
    check("z_done_count", 128'(done_cnt), 128'(7));
    check("z_done_cycle", 128'(last_done_cyc), 128'(k + 1));
    check("z_no_beats", 128'(fire_cyc.size()), 128'(0));

    // Held trigger in mode 0 runs exactly one transfer.
    push_xfer(src_cnt, 4, 32'b1000);
    mode = 2'd0; transfer_size = 4; mss = 0; ifg = 0;
    $display("xfer: mode=0 size=4 mss=0 trigger held, first_beat=%0d", src_cnt);
    @(posedge clk); #1;
    trigger = 1'b1;
    repeat (40) @(posedge clk);
    #1;
    trigger = 1'b0;
    check("hold_one_xfer", 128'(done_cnt), 128'(8));
    wait_drain(20);

    // Reset mid-fragment with downstream stalled and trigger held high.
    fire_cyc.delete();
    tready_fix = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    mode = 2'd0; transfer_size = 10; mss = 5; ifg = 0;
    $display("xfer: mode=0 size=10 mss=5 reset mid-fragment, first_beat=%0d", src_cnt);
    trigger = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    arst = 1'b1;
    @(posedge clk); #1;
    check("rr_m_tvalid", 128'(m_axis_tvalid), 128'(0));
    check("rr_m_tlast", 128'(m_axis_tlast), 128'(0));
    check("rr_s_tready", 128'(s_axis_tready), 128'(0));
    check("rr_init", 128'(transfer_init), 128'(0));
    check("rr_frag_count", 128'(frag_count), 128'(0));
    check("rr_done", 128'(transfer_completed), 128'(0));
    @(posedge clk); #1;
    arst = 1'b0;
    tready_fix = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    check("rr_no_restart", 128'(transfer_init), 128'(0));
    check("rr_no_beats", 128'(fire_cyc.size()), 128'(0));
    trigger = 1'b0;
    push_xfer(src_cnt, 2, 32'b10);
    start(2'd0, 2, 0, 0);
    wait_done(9, 100);
    wait_drain(50);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
